// File: rtl/fetch_queue.sv
// Instruction-fetch stage: reads one word per cycle at fetch_pc into a small FIFO drained by decode.
// Optional FETCH_PERF_EN macro adds push and full-stall counters.
module fetch_queue #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int PC_W       = $clog2(IMEM_DEPTH),
    parameter int QDEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [IMEM_DEPTH*XLEN-1:0] instruction_memory,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [PC_W-1:0]            fetch_pc,
    output logic [$clog2(QDEPTH):0]    q_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_stall
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [XLEN-1:0] imem_words [IMEM_DEPTH];
    logic [XLEN-1:0] q_instr    [QDEPTH];
    logic [PC_W-1:0] q_pc       [QDEPTH];

    logic [PC_W-1:0]  fetch_pc_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] q_count_reg;

    logic pop;
    logic push;
    logic consume;

    generate
        for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_unpack
            assign imem_words[gi] = instruction_memory[gi*XLEN +: XLEN];
        end
    endgenerate

    // A full queue may still accept a push when the head leaves on the same edge;
    // redirect suppresses both push and the actual consumption of the head.
    assign pop     = out_valid & out_ready;
    assign push    = !redirect_valid & ((q_count_reg != FULL_CNT) | pop);
    assign consume = pop & !redirect_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_reg <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            q_count_reg  <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            q_count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                fetch_pc_reg <= fetch_pc_reg + PC_W'(1);
            end
            if (consume) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, consume})
                2'b10:   q_count_reg <= q_count_reg + CNT_W'(1);
                2'b01:   q_count_reg <= q_count_reg - CNT_W'(1);
                default: q_count_reg <= q_count_reg;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by q_count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr_reg] <= imem_words[fetch_pc_reg];
            q_pc[wr_ptr_reg]    <= fetch_pc_reg;
        end
    end

    assign out_valid = (q_count_reg != '0);
    assign out_instr = q_instr[rd_ptr_reg];
    assign out_pc    = q_pc[rd_ptr_reg];
    assign fetch_pc  = fetch_pc_reg;
    assign q_count   = q_count_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (push) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if ((q_count_reg == FULL_CNT) && !pop) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random ready/redirect traffic against a queue model.
module tb_fetch_queue;

    localparam int XLEN       = 32;
    localparam int IMEM_DEPTH = 256;
    localparam int PC_W       = 8;
    localparam int QDEPTH     = 4;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [IMEM_DEPTH*XLEN-1:0] instruction_memory;
    logic                       redirect_valid;
    logic [PC_W-1:0]            redirect_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_instr;
    logic [PC_W-1:0]            out_pc;
    logic [PC_W-1:0]            fetch_pc;
    logic [2:0]                 q_count;
`ifdef FETCH_PERF_EN
    logic [31:0]                perf_fetched;
    logic [31:0]                perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .PC_W(PC_W), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .instruction_memory(instruction_memory),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .fetch_pc(fetch_pc),
        .q_count(q_count)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    logic [XLEN-1:0] mem [IMEM_DEPTH];
    always_comb begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            instruction_memory[i*XLEN +: XLEN] = mem[i];
        end
    end

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] instr;
    } ent_t;

    ent_t        mq[$];
    int          m_fpc;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue model: a redirect empties it; otherwise the head leaves if taken, then a
    // new entry joins whenever there is room, all with plain queue operations.
    task automatic model_step(input logic rdy, input logic rv, input logic [PC_W-1:0] rpc);
        bit mpop;
        mpop = (mq.size() != 0) && rdy;
        if (mq.size() == QDEPTH && !mpop) m_stall++;
        if (rv) begin
            mq.delete();
            m_fpc = int'(rpc);
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mq.size() < QDEPTH) begin
                mq.push_back('{pc: PC_W'(m_fpc), instr: mem[m_fpc]});
                m_fpc = (m_fpc + 1) % IMEM_DEPTH;
                m_fetched++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check_eq({tag, ".count"}, 64'(q_count), 64'(mq.size()));
        check_eq({tag, ".fetch_pc"}, 64'(fetch_pc), 64'(m_fpc));
        if (mq.size() != 0) begin
            check_eq({tag, ".pc"}, 64'(out_pc), 64'(mq[0].pc));
            check_eq({tag, ".instr"}, 64'(out_instr), 64'(mq[0].instr));
        end
`ifdef FETCH_PERF_EN
        check_eq({tag, ".perf_fetched"}, 64'(perf_fetched), 64'(m_fetched));
        check_eq({tag, ".perf_stall"}, 64'(perf_stall), 64'(m_stall));
`endif
        $display("cyc %0d %s rdy=%0b redir=%0b valid=%0b pc=%0h instr=%08h q=%0d fpc=%0h",
                 cyc, tag, out_ready, redirect_valid, out_valid, out_pc, out_instr, q_count, fetch_pc);
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [PC_W-1:0] rpc, input string tag);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        cyc++;
        model_step(rdy, rv, rpc);
        #1;
        compare_model(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc     = 0;
        m_fetched = '0;
        m_stall   = '0;
    endtask

    task automatic do_reset();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        reset_n        = 1'b0;
        model_reset();
        #2;
        compare_model("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [PC_W-1:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 8'd254;
        wrap_exp[1] = 8'd255;
        wrap_exp[2] = 8'd0;
        wrap_exp[3] = 8'd1;
        for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = 32'h100 + i;

        // Free-running delivery in PC order
        do_reset();
        step(1'b1, 1'b0, '0, "stream");
        check_eq("first_pc", 64'(out_pc), 64'd0);
        check_eq("first_instr", 64'(out_instr), 64'h100);
        for (int k = 2; k <= 6; k++) begin
            step(1'b1, 1'b0, '0, "stream");
            check_eq("stream_pc", 64'(out_pc), 64'(k - 1));
        end

        // Back-pressure fills the queue and holds it
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, '0, "stall");
            check_eq("stall_count", 64'(q_count), 64'((k < 4) ? k : 4));
        end
        check_eq("stall_fetch_pc", 64'(fetch_pc), 64'd4);
        check_eq("stall_head", 64'(out_pc), 64'd0);
`ifdef FETCH_PERF_EN
        check_eq("perf_fetched_10", 64'(perf_fetched), 64'd4);
        check_eq("perf_stall_10", 64'(perf_stall), 64'd6);
`endif
        step(1'b1, 1'b0, '0, "drain1");
        check_eq("drain1_pc", 64'(out_pc), 64'd1);
        check_eq("drain1_count", 64'(q_count), 64'd4);

        // Redirect with three entries queued, head offered and discarded
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, "fill3");
        check_eq("fill3_count", 64'(q_count), 64'd3);
        step(1'b1, 1'b1, 8'h40, "redir");
        check_eq("redir_valid", 64'(out_valid), 64'd0);
        check_eq("redir_count", 64'(q_count), 64'd0);
        step(1'b0, 1'b0, '0, "redir_next");
        check_eq("redir_pc", 64'(out_pc), 64'h40);

        // PC wrap at the top of instruction memory
        step(1'b1, 1'b1, 8'd254, "wrap_redir");
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, '0, "wrap");
            check_eq("wrap_pc", 64'(out_pc), 64'(wrap_exp[k]));
        end

        // Back-to-back redirects: last target wins
        step(1'b1, 1'b1, 8'h10, "redir_a");
        step(1'b1, 1'b1, 8'h20, "redir_b");
        step(1'b0, 1'b0, '0, "redir_ab");
        check_eq("redir_last_pc", 64'(out_pc), 64'h20);

        // Asynchronous reset mid-stream
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, "prefill");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_valid", 64'(out_valid), 64'd0);
        compare_model("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, '0, "restart");
        check_eq("restart_pc", 64'(out_pc), 64'd0);

        // Randomised traffic
        for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = $urandom;
        for (int k = 0; k < 400; k++) begin
            step(1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 15) == 0)),
                 PC_W'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling queue. Each cycle it reads one instruction from a flattened instruction-memory bus at the current PC and pushes `{pc, instr}` into a small FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect port flushes the FIFO and reloads the PC, for branches and exceptions. Sits between instruction memory and decode/rename at the front of the out-of-order pipeline.

## Interface
- `XLEN`, 32: instruction width in bits.
- `IMEM_DEPTH`, 256: instruction-memory entries; power of two, ≥2.
- `PC_W`, `$clog2(IMEM_DEPTH)`: PC width; the PC is an entry index, not a byte address.
- `QDEPTH`, 4: fetch-queue entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `instruction_memory` in `IMEM_DEPTH*XLEN`: flattened memory; entry i = bits `[i*XLEN +: XLEN]`.
- `redirect_valid` in 1: flush the queue and load the PC from `redirect_pc`.
- `redirect_pc` in `PC_W`: redirect target index.
- `out_valid` out 1: queue head is valid.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out `XLEN`: head instruction.
- `out_pc` out `PC_W`: PC of the head instruction.
- `fetch_pc` out `PC_W`: PC that will be fetched on the next push.
- `q_count` out `$clog2(QDEPTH)+1`: current occupancy.

## Operation
- State: `fetch_pc`, a circular queue of `QDEPTH` `{pc, instr}` entries, read pointer `rd_ptr`, write pointer `wr_ptr`, and `q_count`.
- `pop = out_valid & out_ready`.
- `push = !redirect_valid & (q_count < QDEPTH | pop)`. A push writes `{fetch_pc, instruction_memory[fetch_pc*XLEN +: XLEN]}` at `wr_ptr`, then `fetch_pc <= fetch_pc + 1`.
- `fetch_pc` wraps from `IMEM_DEPTH-1` to 0 (modulo 2^PC_W). Pointers wrap modulo `QDEPTH`.
- When full, a push is allowed only if a pop occurs in the same cycle. Occupancy then stays at `QDEPTH`.
- `out_valid = (q_count != 0)`. `out_instr` and `out_pc` are driven combinationally from the entry at `rd_ptr`. Their values are don't-care when `out_valid` is 0.
- Redirect has priority over push and pop. The edge with `redirect_valid=1` sets `q_count<=0`, `rd_ptr<=wr_ptr<=0` and `fetch_pc<=redirect_pc`. No entry is consumed or written on that edge. A head presented while redirect is high is discarded, even if `out_ready=1`.
- Consecutive redirects: the last one wins, and no push occurs while `redirect_valid` stays high.
- No other state machine; the block free-runs when not stalled or redirected.

## Timing
- Reset (async, `reset_n=0`) clears: `fetch_pc=0`, `rd_ptr=wr_ptr=0`, `q_count=0`, `out_valid=0`. Queue contents are not reset.
- After reset release, the first rising edge pushes PC 0. `out_valid=1`, `out_pc=0` follow that edge, giving a 1-cycle fetch latency.
- Reset asserted mid-operation discards all queued entries immediately (asynchronously).
- Redirect at edge N: `out_valid=0` after edge N. Edge N+1 pushes `redirect_pc`. `out_valid=1`, `out_pc=redirect_pc` after edge N+1.
- With `out_ready` held high from reset, exactly one instruction is delivered per cycle, in PC order.
- `out_*` stay stable while `out_valid=1` and `out_ready=0`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `perf_fetched` (32 bits): counts pushes.
  - Adds output `perf_stall` (32 bits): counts cycles with `q_count==QDEPTH` and no pop.
  - Both clear on reset and wrap at 2^32. Redirect does not clear them.
- `FETCH_PERF_EN` undefined: neither port nor its counter logic exists. All other behaviour is identical.

## Test plan
- Reset release with `out_ready=1`, memory[i]=i+0x100: after edge 1, `out_pc=0`, `out_instr=0x100`; after edge k, `out_pc=k-1`, one instruction per cycle.
- `out_ready=0` from reset: `q_count` goes 1,2,3,4 over edges 1–4 and holds at 4, `fetch_pc` holds at 4, head stays PC 0. Then `out_ready=1` for one cycle: `out_pc` becomes 1 and `q_count` stays 4.
- Redirect to PC 0x40 while 3 entries are queued: next cycle `out_valid=0`, `q_count=0`; the cycle after, `out_pc=0x40`. No stale PCs ever appear.
- Wrap: redirect to `IMEM_DEPTH-2`=254 with `out_ready=1`: delivered PCs are 254, 255, 0, 1.
- Async reset mid-stream with `q_count=3`: `out_valid` drops with no clock edge. After release, delivery restarts at PC 0.
- With `FETCH_PERF_EN` and `out_ready=0` for 10 cycles from reset: `perf_fetched=4`, `perf_stall=6`.
